// File: rtl/norm_round_pipe.sv
// norm_round_pipe: two-stage normalise-and-round back end shared by the
// add/sub and multiply datapaths, with a valid/ready handshake on both sides.
// Optional feature macro: NORM_ROUND_MODES_EN enables all four rounding modes;
// without it the block always rounds to nearest-even and overflows to +/-Inf.
module norm_round_pipe #(
  parameter int ExponentSize = 8,
  parameter int FractionSize = 23,
  parameter int MantissaSize = FractionSize + 1,
  parameter int DataSize     = 1 + ExponentSize + FractionSize
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        InValid,
  output logic                        InReady,
  input  logic                        MULorADD,
  input  logic                        Sign,
  input  logic [ExponentSize-1:0]     ExponentBase,
  input  logic                        EffCarry,
  input  logic [MantissaSize+2:0]     AdderResult,
  input  logic [2*MantissaSize-1:0]   MULResult,
  input  logic [1:0]                  RoundMode,
  output logic                        OutValid,
  input  logic                        OutReady,
  output logic [DataSize-1:0]         Result,
  output logic                        Overflow,
  output logic                        Underflow,
  output logic                        Inexact
);

  localparam int M    = MantissaSize;
  localparam int E    = ExponentSize;
  localparam int F    = FractionSize;
  localparam int ExpW = E + 2;
  localparam int AddW = M + 3;
  localparam int LzcW = $clog2(AddW + 1);

  localparam logic [ExpW-1:0] ExpInf = {2'b00, {E{1'b1}}};

  typedef enum logic [1:0] {
    RndRne = 2'b00,
    RndRtz = 2'b01,
    RndRup = 2'b10,
    RndRdn = 2'b11
  } roundMode_t;

  // Stage 1 state
  logic             r_valid1;
  logic [M-1:0]     r_mant1;
  logic             r_g1;
  logic             r_s1;
  logic             r_sign1;
  logic             r_zero1;
  logic [ExpW-1:0]  r_exp1;

  // Stage 2 state
  logic                r_valid2;
  logic [DataSize-1:0] r_result;
  logic                r_ovf;
  logic                r_unf;
  logic                r_inx;

  // Stage 1 combinational
  logic [LzcW-1:0]  w_lzc;
  logic [AddW-1:0]  w_shifted;
  logic [ExpW-1:0]  w_baseExt;
  logic [M-1:0]     w_mant1;
  logic             w_g1;
  logic             w_s1;
  logic             w_zero1;
  logic [ExpW-1:0]  w_exp1;

  // Stage 2 combinational
  logic                w_ready2;
  roundMode_t          w_mode;
  logic                w_gs;
  logic                w_inc;
  logic [M:0]          w_sum;
  logic [F-1:0]        w_mantR;
  logic [ExpW-1:0]     w_expR;
  logic                w_ovfR;
  logic                w_unfR;
  logic                w_toInf;
  logic [DataSize-1:0] w_resultR;
  logic                w_ovfFlag;
  logic                w_unfFlag;
  logic                w_inxFlag;

`ifdef NORM_ROUND_MODES_EN
  logic [1:0] r_mode1;
  assign w_mode  = roundMode_t'(r_mode1);
  assign w_toInf = (w_mode == RndRne) |
                   ((w_mode == RndRup) & ~r_sign1) |
                   ((w_mode == RndRdn) & r_sign1);
`else
  logic w_unusedMode;
  assign w_unusedMode = ^RoundMode;
  assign w_mode       = RndRne;
  assign w_toInf      = 1'b1;
`endif

  assign w_ready2  = ~r_valid2 | OutReady;
  assign InReady   = ~r_valid1 | w_ready2;
  assign w_baseExt = {2'b00, ExponentBase};
  assign w_shifted = AdderResult << w_lzc;

  // Leading-zero count of the raw adder result; the highest set bit wins
  always_comb begin
    w_lzc = LzcW'(AddW);
    for (int i = 0; i < AddW; i++) begin
      if (AdderResult[i]) w_lzc = LzcW'(AddW - 1 - i);
    end
  end

  // Normalise either the adder or product path into mantissa, guard, sticky, exponent
  always_comb begin
    w_mant1 = '0;
    w_g1    = 1'b0;
    w_s1    = 1'b0;
    w_zero1 = 1'b0;
    w_exp1  = w_baseExt;
    if (MULorADD) begin
      if (MULResult[2*M-1]) begin
        w_mant1 = MULResult[2*M-1 -: M];
        w_g1    = MULResult[M-1];
        w_s1    = |MULResult[M-2:0];
        w_exp1  = w_baseExt + {{(ExpW-1){1'b0}}, 1'b1};
      end else begin
        w_mant1 = MULResult[2*M-2 -: M];
        w_g1    = MULResult[M-2];
        w_s1    = |MULResult[M-3:0];
      end
    end else if (EffCarry) begin
      w_mant1 = {1'b1, AdderResult[AddW-1:4]};
      w_g1    = AdderResult[3];
      w_s1    = |AdderResult[2:0];
      w_exp1  = w_baseExt + {{(ExpW-1){1'b0}}, 1'b1};
    end else begin
      w_mant1 = w_shifted[AddW-1:3];
      w_g1    = w_shifted[2];
      w_s1    = |w_shifted[1:0];
      w_exp1  = w_baseExt - {{(ExpW-LzcW){1'b0}}, w_lzc};
      w_zero1 = (AdderResult == '0);
    end
  end

  // Stage 1 register: occupancy follows the handshake, data loads only on accept
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid1 <= 1'b0;
      r_mant1  <= '0;
      r_g1     <= 1'b0;
      r_s1     <= 1'b0;
      r_sign1  <= 1'b0;
      r_zero1  <= 1'b0;
      r_exp1   <= '0;
`ifdef NORM_ROUND_MODES_EN
      r_mode1  <= 2'b00;
`endif
    end else begin
      if (InReady) r_valid1 <= InValid;
      if (InValid && InReady) begin
        r_mant1 <= w_mant1;
        r_g1    <= w_g1;
        r_s1    <= w_s1;
        r_sign1 <= Sign;
        r_zero1 <= w_zero1;
        r_exp1  <= w_exp1;
`ifdef NORM_ROUND_MODES_EN
        r_mode1 <= RoundMode;
`endif
      end
    end
  end

  // Round increment from the mode, then renormalise on mantissa carry-out
  always_comb begin
    w_gs = r_g1 | r_s1;
    case (w_mode)
      RndRne:  w_inc = r_g1 & (r_s1 | r_mant1[0]);
      RndRtz:  w_inc = 1'b0;
      RndRup:  w_inc = ~r_sign1 & w_gs;
      RndRdn:  w_inc = r_sign1 & w_gs;
      default: w_inc = 1'b0;
    endcase
    w_sum   = {1'b0, r_mant1} + {{M{1'b0}}, w_inc};
    w_mantR = w_sum[M] ? w_sum[M-1:1] : w_sum[M-2:0];
    w_expR  = r_exp1 + {{(ExpW-1){1'b0}}, w_sum[M]};
    w_ovfR  = $signed(w_expR) >= $signed(ExpInf);
    w_unfR  = w_expR[ExpW-1] | (w_expR == '0);
  end

  // Exception handling and packing of the final word
  always_comb begin
    w_resultR = {r_sign1, w_expR[E-1:0], w_mantR};
    w_ovfFlag = 1'b0;
    w_unfFlag = 1'b0;
    w_inxFlag = w_gs;
    if (r_zero1) begin
      w_resultR = {r_sign1, {(DataSize-1){1'b0}}};
      w_inxFlag = 1'b0;
    end else if (w_ovfR) begin
      w_resultR = w_toInf ? {r_sign1, {E{1'b1}}, {F{1'b0}}}
                          : {r_sign1, {(E-1){1'b1}}, 1'b0, {F{1'b1}}};
      w_ovfFlag = 1'b1;
      w_inxFlag = 1'b1;
    end else if (w_unfR) begin
      w_resultR = {r_sign1, {(DataSize-1){1'b0}}};
      w_unfFlag = 1'b1;
      w_inxFlag = 1'b1;
    end
  end

  // Stage 2 register: holds result and flags while downstream stalls
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_valid2 <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
    end else begin
      if (w_ready2) r_valid2 <= r_valid1;
      if (r_valid1 && w_ready2) begin
        r_result <= w_resultR;
        r_ovf    <= w_ovfFlag;
        r_unf    <= w_unfFlag;
        r_inx    <= w_inxFlag;
      end
    end
  end

  assign OutValid  = r_valid2;
  assign Result    = r_result;
  assign Overflow  = r_ovf;
  assign Underflow = r_unf;
  assign Inexact   = r_inx;

endmodule

// File: tb/tb_norm_round_pipe.sv
// Scoreboard bench for norm_round_pipe: directed cases, randomized traffic
// against a value-level rounding model, backpressure and mid-stream reset.
module tb_norm_round_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic        MULorADD;
  logic        Sign;
  logic [7:0]  ExponentBase;
  logic        EffCarry;
  logic [26:0] AdderResult;
  logic [47:0] MULResult;
  logic [1:0]  RoundMode;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;

`ifdef NORM_ROUND_MODES_EN
  localparam bit modesEn = 1'b1;
`else
  localparam bit modesEn = 1'b0;
`endif

  typedef struct packed {
    logic        mul;
    logic        sign;
    logic [7:0]  base;
    logic        effCarry;
    logic [26:0] adder;
    logic [47:0] mulRes;
    logic [1:0]  mode;
  } op_t;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  flags;
  } exp_t;

  exp_t scbQ[$];
  int   total = 0;
  int   bad = 0;
  int   readyMode = 1;

  norm_round_pipe dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .MULorADD(MULorADD), .Sign(Sign), .ExponentBase(ExponentBase),
    .EffCarry(EffCarry), .AdderResult(AdderResult), .MULResult(MULResult),
    .RoundMode(RoundMode), .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .Overflow(Overflow), .Underflow(Underflow), .Inexact(Inexact)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Rounds the exact significand value by comparing the discarded remainder against half an ulp
  function automatic exp_t refModel(input op_t op);
    exp_t ex;
    longint unsigned v, mant, rem, half;
    int p, refPos, e, shift;
    bit up, inx, toInf;
    logic [1:0] mode;
    mode = modesEn ? op.mode : 2'b00;
    ex.flags = 3'b000;
    if (!op.mul && !op.effCarry && op.adder == 27'd0) begin
      ex.result = {op.sign, 31'b0};
      return ex;
    end
    if (op.mul) begin
      v = longint'(op.mulRes);
      refPos = 46;
    end else if (op.effCarry) begin
      v = (64'd1 << 27) | longint'(op.adder);
      refPos = 26;
    end else begin
      v = longint'(op.adder);
      refPos = 26;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    e = int'(op.base) + p - refPos;
    if (p > 23) begin
      shift = p - 23;
      mant  = v >> shift;
      rem   = v & ((64'd1 << shift) - 1);
      half  = 64'd1 << (shift - 1);
    end else begin
      mant = v << (23 - p);
      rem  = 0;
      half = 1;
    end
    inx = (rem != 0);
    case (mode)
      2'b00:   up = (rem > half) || ((rem == half) && mant[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !op.sign && inx;
      default: up = op.sign && inx;
    endcase
    mant = mant + longint'(up);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    toInf = (mode == 2'b00) || (mode == 2'b10 && !op.sign) || (mode == 2'b11 && op.sign);
    if (e >= 255) begin
      ex.result = toInf ? {op.sign, 8'hFF, 23'h0} : {op.sign, 8'hFE, 23'h7FFFFF};
      ex.flags  = 3'b101;
    end else if (e <= 0) begin
      ex.result = {op.sign, 31'b0};
      ex.flags  = 3'b011;
    end else begin
      ex.result = {op.sign, 8'(e), mant[22:0]};
      ex.flags  = {2'b00, inx};
    end
    return ex;
  endfunction

  function automatic op_t mkAdd(input logic s, input logic [7:0] b, input logic c,
                                input logic [26:0] a, input logic [1:0] m);
    op_t op;
    op.mul = 1'b0; op.sign = s; op.base = b; op.effCarry = c;
    op.adder = a; op.mulRes = 48'h0; op.mode = m;
    return op;
  endfunction

  function automatic op_t mkMul(input logic s, input logic [7:0] b,
                                input logic [47:0] r, input logic [1:0] m);
    op_t op;
    op.mul = 1'b1; op.sign = s; op.base = b; op.effCarry = 1'b0;
    op.adder = 27'h0; op.mulRes = r; op.mode = m;
    return op;
  endfunction

  function automatic exp_t mkExp(input logic [31:0] r, input logic [2:0] f);
    exp_t ex;
    ex.result = r;
    ex.flags  = f;
    return ex;
  endfunction

  function automatic op_t randOp();
    op_t op;
    op.mul      = 1'($urandom_range(0, 1));
    op.sign     = 1'($urandom_range(0, 1));
    op.base     = 8'($urandom_range(0, 255));
    op.mode     = 2'($urandom_range(0, 3));
    op.effCarry = ($urandom_range(0, 3) == 0);
    op.adder    = 27'($urandom) >> $urandom_range(0, 26);
    if ($urandom_range(0, 7) == 0) op.adder = 27'h7FFFFF8 | 27'($urandom_range(0, 7));
    if ($urandom_range(0, 15) == 0) op.adder = 27'h0;
    op.mulRes   = {16'($urandom), $urandom};
    if (!op.mulRes[47]) op.mulRes[46] = 1'b1;
    return op;
  endfunction

  task automatic driveOp(input op_t op);
    MULorADD     = op.mul;
    Sign         = op.sign;
    ExponentBase = op.base;
    EffCarry     = op.effCarry;
    AdderResult  = op.adder;
    MULResult    = op.mulRes;
    RoundMode    = op.mode;
    InValid      = 1'b1;
  endtask

  task automatic waitAccept(input exp_t ex);
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge Clk);
      if (InReady) begin
        scbQ.push_back(ex);
        done = 1'b1;
      end
      @(posedge Clk);
      #1;
    end
    InValid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: actual=no_accept required=accept at %0t", $time);
    end
  endtask

  task automatic applyStimulus(input op_t op, input exp_t ex);
    driveOp(op);
    waitAccept(ex);
  endtask

  task automatic waitDrain();
    int c = 0;
    while (scbQ.size() != 0 && c < 300) begin
      @(posedge Clk);
      #1;
      c++;
    end
    if (scbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: actual=%0d pending required=0", scbQ.size());
    end
  endtask

  // Downstream ready: forced low, forced high, or random
  initial begin
    OutReady = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (readyMode)
        0:       OutReady = 1'b0;
        1:       OutReady = 1'b1;
        default: OutReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the oldest expectation whenever a result is handed over
  initial begin : monitor
    exp_t ex;
    forever begin
      @(negedge Clk);
      if (!Reset && OutValid && OutReady) begin
        if (scbQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_output: actual=%h required=none at %0t", Result, $time);
        end else begin
          ex = scbQ.pop_front();
          checkOutput("result", Result, ex.result);
          checkOutput("flags_ovf_unf_inx", {29'b0, Overflow, Underflow, Inexact}, {29'b0, ex.flags});
        end
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_t  op;
    op_t  opA, opB, opC;
    exp_t exA, exB, exC;

    Reset = 1'b0; InValid = 1'b0; MULorADD = 1'b0; Sign = 1'b0; ExponentBase = 8'h0;
    EffCarry = 1'b0; AdderResult = 27'h0; MULResult = 48'h0; RoundMode = 2'b00;
    #1 Reset = 1'b1;
    #2;
    checkOutput("rst_outvalid", {31'b0, OutValid}, 32'd0);
    checkOutput("rst_result", Result, 32'h0);
    checkOutput("rst_flags", {29'b0, Overflow, Underflow, Inexact}, 32'd0);
    #9 Reset = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("rst_inready", {31'b0, InReady}, 32'd1);

    // Directed cases
    applyStimulus(mkAdd(1'b0, 8'h7F, 1'b0, 27'h4000000, 2'b00), mkExp(32'h3F800000, 3'b000));
    applyStimulus(mkAdd(1'b0, 8'h7F, 1'b1, 27'h4000000, 2'b00), mkExp(32'h40400000, 3'b000));
    applyStimulus(mkAdd(1'b0, 8'h7F, 1'b0, 27'h0000008, 2'b00), mkExp(32'h34000000, 3'b000));
    applyStimulus(mkMul(1'b0, 8'h7F, 48'h800001800000, 2'b00), mkExp(32'h40000002, 3'b001));
    applyStimulus(mkMul(1'b0, 8'h7F, 48'h800001800000, 2'b01),
                  modesEn ? mkExp(32'h40000001, 3'b001) : mkExp(32'h40000002, 3'b001));
    applyStimulus(mkAdd(1'b0, 8'h7F, 1'b0, 27'h7FFFFFC, 2'b00), mkExp(32'h40000000, 3'b001));
    applyStimulus(mkAdd(1'b0, 8'hFE, 1'b0, 27'h7FFFFFC, 2'b00), mkExp(32'h7F800000, 3'b101));
    applyStimulus(mkAdd(1'b0, 8'hFE, 1'b0, 27'h7FFFFFC, 2'b01),
                  modesEn ? mkExp(32'h7F7FFFFF, 3'b001) : mkExp(32'h7F800000, 3'b101));
    applyStimulus(mkAdd(1'b1, 8'h55, 1'b0, 27'h0, 2'b00), mkExp(32'h80000000, 3'b000));
    applyStimulus(mkAdd(1'b1, 8'h10, 1'b0, 27'h0000008, 2'b00), mkExp(32'h80000000, 3'b011));
    applyStimulus(mkAdd(1'b1, 8'hFE, 1'b1, 27'h4000000, 2'b10),
                  modesEn ? mkExp(32'hFF7FFFFF, 3'b101) : mkExp(32'hFF800000, 3'b101));
    waitDrain();

    // Backpressure: two accepts fill the pipe, the third must stall
    opA = mkAdd(1'b0, 8'h7F, 1'b0, 27'h4000000, 2'b00); exA = mkExp(32'h3F800000, 3'b000);
    opB = mkAdd(1'b0, 8'h7F, 1'b0, 27'h0000008, 2'b00); exB = mkExp(32'h34000000, 3'b000);
    opC = mkAdd(1'b0, 8'h7F, 1'b1, 27'h4000000, 2'b00); exC = mkExp(32'h40400000, 3'b000);
    readyMode = 0;
    repeat (2) begin @(posedge Clk); #1; end
    applyStimulus(opA, exA);
    applyStimulus(opB, exB);
    driveOp(opC);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      checkOutput("bp_inready", {31'b0, InReady}, 32'd0);
      checkOutput("bp_outvalid", {31'b0, OutValid}, 32'd1);
      checkOutput("bp_hold_result", Result, exA.result);
      @(posedge Clk);
      #1;
    end
    readyMode = 1;
    waitAccept(exC);
    waitDrain();

    // Randomized traffic with random downstream stalls
    readyMode = 2;
    for (int n = 0; n < 300; n++) begin
      op = randOp();
      applyStimulus(op, refModel(op));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge Clk);
        #1;
      end
    end
    readyMode = 1;
    waitDrain();

    // Reset with operations in flight
    readyMode = 0;
    repeat (2) begin @(posedge Clk); #1; end
    applyStimulus(opA, exA);
    applyStimulus(opB, exB);
    #3 Reset = 1'b1;
    #2;
    checkOutput("midrst_outvalid", {31'b0, OutValid}, 32'd0);
    checkOutput("midrst_result", Result, 32'h0);
    checkOutput("midrst_flags", {29'b0, Overflow, Underflow, Inexact}, 32'd0);
    scbQ.delete();
    #2 Reset = 1'b0;
    readyMode = 1;
    @(posedge Clk);
    #1;
    checkOutput("postrst_inready", {31'b0, InReady}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      checkOutput("postrst_no_output", {31'b0, OutValid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/norm_round_pipe.md
# norm_round_pipe

Parametrised, two-stage pipelined normalise-and-round back end shared by the add/sub and multiply datapaths. Takes the raw adder result (mantissa + guard/round/sticky) or the raw full-width product, plus base exponent and sign. Normalises internally with its own leading-zero count, rounds, renormalises on rounding carry-out, and flags overflow, underflow and inexact. Emits a packed IEEE-style word behind a valid/ready handshake.

## Interface
- `ExponentSize`, default 8: exponent width.
- `FractionSize`, default 23: stored fraction width.
- `MantissaSize`, default FractionSize+1: derived; do not override.
- `DataSize`, default 1+ExponentSize+FractionSize: derived; packed result width.

- `Clk` input 1: clock, rising edge.
- `Reset` input 1: asynchronous, active-high.
- `InValid` input 1: input operand valid.
- `InReady` output 1: stage can accept an input this cycle.
- `MULorADD` input 1: selects the path; 1 = MUL path, 0 = ADD path.
- `Sign` input 1: result sign.
- `ExponentBase` input ExponentSize: biased exponent before normalisation.
- `EffCarry` input 1: adder carry-out (ADD path).
- `AdderResult` input MantissaSize+3: bits [M+2:3] are the mantissa, [2] is guard, [1] is round, [0] is sticky.
- `MULResult` input 2*MantissaSize: raw product.
- `RoundMode` input 2: rounding mode; 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
- `OutValid` output 1: result valid.
- `OutReady` input 1: downstream accepts the result.
- `Result` output DataSize: {sign, exponent, fraction}.
- `Overflow`, `Underflow`, `Inexact` outputs 1: exception flags, qualified by OutValid.

## Operation
- **Stage 1 (normalise).** Registers mantissa (M bits), G, S, sign, mode, and exponent. The exponent is held at ExponentSize+2 bits, signed.
  - ADD, EffCarry=1: mantissa = {1, AdderResult[M+2:4]}. G = AdderResult[3]. S = |AdderResult[2:0]. Exp = ExponentBase+1.
  - ADD, EffCarry=0: LZC = leading zeros of AdderResult, range 0..M+3. Shift left by LZC. Mantissa = [M+2:3], G = [2], S = [1]|[0]. Exp = ExponentBase−LZC.
  - ADD with AdderResult==0 and EffCarry=0: zero flag is set. Result = {Sign, all zeros}. No flags are raised.
  - MUL with MULResult MSB=1: mantissa = [2M−1:M], G = [M−1], S = |[M−2:0]. Exp = ExponentBase+1.
  - MUL with MSB=0: mantissa = [2M−2:M−1], G = [M−2], S = |[M−3:0]. Exp = ExponentBase.
- **Stage 2 (round).** Computes an increment from the mode:
  - RNE: G&(S|L).
  - RTZ: 0.
  - RUP: ~Sign&(G|S).
  - RDN: Sign&(G|S).
  - Inexact = G|S.
  - If the mantissa carries out on increment, mantissa = 1.000… and Exp+1.
- **Overflow.** Final Exp ≥ 2^E−1 sets Overflow=1 and Inexact=1.
  - Result is ±Inf under RNE.
  - Under RUP/RDN, result is ±Inf in the direction of rounding and max finite (exp 2^E−2, fraction all ones) otherwise.
  - Under RTZ, result is max finite.
- **Underflow.** Final Exp ≤ 0 (signed) sets Underflow=1 and Inexact=1. Result is flushed to {Sign, zeros}; no subnormals are produced.
- **Packing.** Result = {Sign, Exp[E−1:0], mantissa[M−2:0]}.

## Timing
- Latency: 2 cycles from accepted input (InValid&InReady) to OutValid.
- Full throughput of 1 result per cycle when OutReady=1.
- Stage-2 ready = ~Valid2 | OutReady.
- InReady = ~Valid1 | stage-2 ready. This is combinational from OutReady.
- While OutValid&~OutReady:
  - Result and the flags hold stable.
  - Valid2 holds.
  - Stage 1 holds if occupied.
  - The pipeline absorbs at most 2 operations.
- Simultaneous accept and drain in the same cycle: both occur, and the stage stays occupied.
- Reset (asynchronous, any time, including mid-flight):
  - Valid1, Valid2, OutValid = 0.
  - Result = 0; Overflow, Underflow, Inexact = 0.
  - InReady = 1 from the first cycle after deassertion.
- Data registers load only on a handshake. Inputs are sampled only when InValid&InReady.

## Configuration
- `NORM_ROUND_MODES_EN` defined: RoundMode is honoured for all four modes, as described above.
- Not defined: RoundMode is ignored and hard-wired to RNE. Overflow always yields ±Inf. The mode register and its mux are removed.

## Test plan
1. ADD normalised: AdderResult=27'h4000000, EffCarry=0, ExponentBase=8'h7F, Sign=0 → after 2 cycles Result=32'h3F800000, all flags 0.
2. ADD carry: same AdderResult with EffCarry=1 → Result=32'h40400000.
3. ADD deep normalise: AdderResult=27'h0000008, ExponentBase=8'h7F → LZC=23, Result=32'h34000000.
4. MUL tie-to-even: MULResult=48'h800001800000, ExponentBase=8'h7F, RNE → Result=32'h40000002, Inexact=1. Same input under RTZ → 32'h40000001.
5. Rounding carry-out and overflow:
   - AdderResult=27'h7FFFFFC, ExponentBase=8'h7F, RNE → 32'h40000000.
   - ExponentBase=8'hFE → 32'h7F800000, Overflow=1.
   - ExponentBase=8'hFE with RTZ and the macro defined → 32'h7F7FFFFF.
6. Backpressure and reset:
   - Hold OutReady=0 and issue 3 back-to-back inputs → InReady falls after 2 accepts; Result is held unchanged.
   - Assert OutReady → results drain in order, one per cycle.
   - Assert Reset mid-stream → OutValid=0 immediately, and nothing is emitted afterwards.
